// File: rtl/reg_file_pkg.sv
// Shared constants and dump-engine state encoding
// for the write-back register file.
package reg_file_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } dump_state_t;

endpackage

// File: rtl/reg_dump_fsm.sv
// Debug dump engine: walks every register index once
// and streams its contents over a valid/ready handshake.
module reg_dump_fsm
   import reg_file_pkg::*;
#(
   parameter int AW = reg_file_pkg::ADDR_W,
   parameter int DW = reg_file_pkg::DATA_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dump_start,
   input  logic          dump_ready,
   input  logic [DW-1:0] rd_data,
   output logic          dump_valid,
   output logic [AW-1:0] dump_index,
   output logic [DW-1:0] dump_data,
   output logic          dump_busy,
   output logic          dump_done
);

   dump_state_t   state, state_n;
   logic [AW-1:0] ptr, ptr_n;

   // State and pointer registers; reset aborts a dump at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
      end
   end

   // Next-state, pointer advance and handshake outputs
   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      dump_valid = 1'b0;
      dump_busy  = 1'b1;
      dump_done  = 1'b0;
      unique case (state)
         IDLE: begin
            dump_busy = 1'b0;
            if (dump_start) begin
               state_n = SCAN;
               ptr_n   = '0;
            end
         end
         SCAN: begin
            dump_valid = 1'b1;
            if (dump_ready) begin
               if (&ptr) state_n = DONE;
               else      ptr_n   = ptr + 1'b1;
            end
         end
         DONE: begin
            dump_done = 1'b1;
            state_n   = IDLE;
            ptr_n     = '0;
         end
         default: begin
            state_n = IDLE;
            ptr_n   = '0;
         end
      endcase
   end

   assign dump_index = ptr;
   assign dump_data  = rd_data;

endmodule

// File: rtl/reg_file_writeback.sv
// 32x32 register file with write-back port, two bypassed
// read ports and a debug dump engine.
module reg_file_writeback
   import reg_file_pkg::*;
#(
   parameter int DATA_W = reg_file_pkg::DATA_W,
   parameter int ADDR_W = reg_file_pkg::ADDR_W,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_index,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_busy,
   output logic              dump_done
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] dump_rd;
   logic              wr_en;

   assign wr_en = RegWrite && (WriteReg != '0);

   // Array update; index 0 is never written so it stays zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[WriteReg] <= WriteData;
      end
   end

   // Operand read ports with optional same-cycle forwarding
   always_comb begin
      ReadData1 = regs[ReadReg1];
      ReadData2 = regs[ReadReg2];
      if (BYPASS && wr_en && WriteReg == ReadReg1)
         ReadData1 = WriteData;
      if (BYPASS && wr_en && WriteReg == ReadReg2)
         ReadData2 = WriteData;
      if (ReadReg1 == '0) ReadData1 = '0;
      if (ReadReg2 == '0) ReadData2 = '0;
   end

   assign dump_rd = regs[dump_index];

   reg_dump_fsm #(
      .AW (ADDR_W),
      .DW (DATA_W)
   ) u_dump (
      .clk        (clk),
      .rst        (rst),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .rd_data    (dump_rd),
      .dump_valid (dump_valid),
      .dump_index (dump_index),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );

endmodule
